// File: rtl/uart_frame_tx.sv
// uart_frame_tx: FIFO-buffered UART transmitter with optional parity and 1 or 2 stop bits
// clk/resetn: rising-edge clock, asynchronous active-low reset
// data/write: byte and enqueue strobe; full: FIFO at capacity; overflow: sticky dropped-write flag
// busy: frame in flight or bytes queued; tx: registered serial line, idle high
module uart_frame_tx #(
  parameter int CLOCK_HZ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] data,
  input  logic       write,
  output logic       full,
  output logic       busy,
  output logic       overflow,
  output logic       tx
);
  localparam int CPB = CLOCK_HZ / BAUD_RATE;
  localparam int CW  = $clog2(CPB);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int NW  = $clog2(FIFO_DEPTH + 1);
  if (CPB < 2) begin : g_bad_baud
    $error("CLOCK_HZ / BAUD_RATE must be at least 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("PARITY must be 0, 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
  state_t          state;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [NW-1:0]   count;
  logic [7:0]      shreg;
  logic            par_bit;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic            last, stop_done, pop, push;
  assign last      = cnt == CW'(CPB - 1);
  assign stop_done = state == ST_STOP && last && bit_idx == 3'(STOP_BITS - 1);
  assign pop       = count != '0 && (state == ST_IDLE || stop_done);
  assign push      = write && !full;
  assign full      = count == NW'(FIFO_DEPTH);
  assign busy      = state != ST_IDLE || count != '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= data;
  // A write while full is dropped even if the same edge pops, so push ignores pop.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + NW'(push) - NW'(pop);
      if (write && full) overflow <= 1'b1;
    end
  // Parity is computed once at pop time; the shift register then only feeds data bits.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state   <= ST_IDLE;
      tx      <= 1'b1;
      shreg   <= '0;
      par_bit <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      cnt <= (state == ST_IDLE || last) ? '0 : cnt + 1'b1;
      if (pop) begin
        shreg   <= mem[rd_ptr];
        par_bit <= ^mem[rd_ptr] ^ (PARITY == 1);
        bit_idx <= '0;
        state   <= ST_START;
        tx      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: tx <= 1'b1;
          ST_START:
            if (last) begin
              state <= ST_DATA;
              tx    <= shreg[0];
            end
          ST_DATA:
            if (last) begin
              if (bit_idx == 3'd7) begin
                bit_idx <= '0;
                state   <= PARITY != 0 ? ST_PARITY : ST_STOP;
                tx      <= PARITY != 0 ? par_bit : 1'b1;
              end else begin
                bit_idx <= bit_idx + 3'd1;
                tx      <= shreg[1];
                shreg   <= shreg >> 1;
              end
            end
          ST_PARITY:
            if (last) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end
          ST_STOP:
            if (last) begin
              if (bit_idx == 3'(STOP_BITS - 1)) begin
                bit_idx <= '0;
                state   <= ST_IDLE;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
              tx <= 1'b1;
            end
          default: begin
            state <= ST_IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
endmodule
